md_rx_ctrl: RTL and testbench
=============================

// Module: md_rx_ctrl
// PURPOSE
//  Front-end slave of the MD RX port. Accepts MD transfers from the upstream master and checks
//  offset/size legality. Answers each transfer with ready (plus err for illegal ones).
//  Legal transfers are buffered in a small FIFO and streamed to the downstream aligner core.
//  All MD RX protocol rules (valid hold, field stability, err only on transfer) hold by construction.
// PARAMETERS
//  ALGN_DATA_WIDTH  32                       MD data bus width in bits (multiple of 8, >=8)
//  FIFO_DEPTH       4                        entries in output FIFO (power of 2, >=2)
//  BUS_BYTES        ALGN_DATA_WIDTH/8        derived; bytes per bus word
//  OFFSET_W         max(1,$clog2(BUS_BYTES)) derived; offset field width
//  SIZE_W           $clog2(BUS_BYTES)+1      derived; size field width
//  CNT_W            $clog2(FIFO_DEPTH)+1     derived; FIFO level width
// PORTS
//  clk            in   1                one clock, all logic on posedge
//  reset          in   1                synchronous, active-high reset
//  md_rx_valid    in   1                upstream transfer request
//  md_rx_data     in   ALGN_DATA_WIDTH  upstream data word
//  md_rx_offset   in   OFFSET_W         byte offset of first valid byte
//  md_rx_size     in   SIZE_W           number of valid bytes
//  md_rx_ready    out  1                transfer completes this cycle (registered)
//  md_rx_err      out  1                completing transfer is illegal (registered)
//  out_valid      out  1                FIFO head valid (= !empty)
//  out_data       out  ALGN_DATA_WIDTH  FIFO head data
//  out_offset     out  OFFSET_W         FIFO head offset
//  out_size       out  SIZE_W           FIFO head size
//  out_ready      in   1                downstream pops head when out_valid&&out_ready
//  fifo_lvl       out  CNT_W            current FIFO occupancy
//  err_cnt        out  8                illegal transfers seen, saturates at 255
// BEHAVIOUR
//  Reset (sync, high): FSM->IDLE; md_rx_ready=0, md_rx_err=0, FIFO empty (out_valid=0, fifo_lvl=0),
//   err_cnt=0. Reset mid-transfer discards the pending response; the master must re-present its transfer.
//  Legality (combinational on current fields): size!=0 && offset+size<=BUS_BYTES && offset%size==0.
//   Evaluate the sum at SIZE_W+1 bits; no wrap is allowed.
//  FSM states:
//   IDLE: if md_rx_valid && (fifo_lvl<FIFO_DEPTH || !legal) -> RESP; register md_rx_ready=1, md_rx_err=!legal.
//         Otherwise stay in IDLE with ready=0, which backpressures the master.
//   RESP: ready=1 for exactly one cycle, and the transfer completes. Legal: push {data,offset,size}.
//         Illegal: no push, err_cnt++. Clear ready/err next cycle -> IDLE.
//  Throughput: at most one transfer per 2 cycles. Latency from valid to ready: 1 cycle when there is space.
//  md_rx_err is never 1 while md_rx_ready is 0.
//  An illegal transfer is answered even when the FIFO is full, because it needs no slot.
//  Space is checked in IDLE. Only one push can be pending, and pops only free space,
//   so a push in RESP never overflows.
//  Simultaneous push and pop: fifo_lvl is unchanged and the data order is preserved.
//   A pop at full in the same cycle as an IDLE check is not seen until the next cycle.
//  The FIFO head is held stable while out_valid && !out_ready. Output fields come straight from registers.
//  Pointers wrap modulo FIFO_DEPTH. fifo_lvl is kept separately (CNT_W bits) to tell full from empty.
//  The output has no err path: illegal data never reaches the core.
// STRUCTURE
//  md_pkg: md_state_t enum {IDLE,RESP}; function md_legal(offset,size,bus_bytes);
//   width helpers for OFFSET_W and SIZE_W.
//  Sub-module md_sync_fifo #(WIDTH,DEPTH): push/pop/full/empty/lvl,
//   registered storage, show-ahead head. md_rx_ctrl = FSM + legality + err counter + one md_sync_fifo.
//  Bind the existing MD protocol checker to the md_rx_* pins in every test.
// TESTING (BUS_BYTES=4, FIFO_DEPTH=4)
//  1 Legal: valid, off=0,size=4,data=0xDEADBEEF -> ready at cycle+1, err=0;
//    out_valid next cycle with the same fields; fifo_lvl=1.
//  2 Illegal: (off=1,size=2), (off=2,size=4), (off=0,size=0) -> each gets ready=1,err=1;
//    no push; err_cnt=3.
//  3 Full: out_ready=0, push 4 legal words -> 5th held with ready=0; the 5th gets ready only
//    1 cycle after out_ready pulses for 1 cycle; order is preserved.
//  4 Illegal at full: FIFO full, send off=3,size=2 -> ready=1,err=1 at once; fifo_lvl stays 4.
//  5 Stream: out_ready=1, 8 back-to-back legal transfers -> one ready every 2 cycles;
//    fifo_lvl never exceeds 1; data in order.
//  6 Reset in RESP: assert reset in the ready cycle -> next cycle all outputs are 0;
//    err_cnt=0; no push occurred.

Source files
------------

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared types and helpers for the MD RX front end
// Contents: md_state_t (responder FSM states), width helpers for the
// offset/size fields, and md_legal() transfer legality check.
package md_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } md_state_t;

  // Offset field is at least one bit wide even for a one-byte bus.
  function automatic int md_offset_w(input int bus_bytes);
    return (bus_bytes > 1) ? $clog2(bus_bytes) : 1;
  endfunction

  // Size must be able to express BUS_BYTES itself, hence the extra bit.
  function automatic int md_size_w(input int bus_bytes);
    return $clog2(bus_bytes) + 1;
  endfunction

  // Operands arrive zero-extended to 32 bits, so offset+size cannot wrap.
  function automatic logic md_legal(input logic [31:0] offset,
                                    input logic [31:0] size,
                                    input logic [31:0] bus_bytes);
    if (size == 32'd0) begin
      return 1'b0;
    end
    return ((offset + size) <= bus_bytes) && ((offset % size) == 32'd0);
  endfunction

endpackage

// File: rtl/md_sync_fifo.sv
// rtl/md_sync_fifo.sv - single-clock show-ahead FIFO with occupancy count
// Ports: clk, reset (sync, active-high); push/push_data write side;
// pop/head_data read side (head visible whenever !empty);
// full, empty, lvl status. Push at full is accepted only together with a pop.
module md_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] lvl
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (lvl == CNT_W'(DEPTH));
  assign empty     = (lvl == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

endmodule

// File: rtl/md_rx_ctrl.sv
// rtl/md_rx_ctrl.sv - MD RX slave: legality check, response FSM, output FIFO
// Ports: clk, reset (sync, active-high); md_rx_valid/data/offset/size in,
// md_rx_ready/md_rx_err out (registered); out_valid/data/offset/size with
// out_ready toward the aligner core; fifo_lvl occupancy; err_cnt (saturating).
module md_rx_ctrl
  import md_pkg::*;
#(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int BUS_BYTES = ALGN_DATA_WIDTH / 8,
  localparam int OFFSET_W = md_offset_w(BUS_BYTES),
  localparam int SIZE_W = md_size_w(BUS_BYTES),
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0] md_rx_data,
  input  logic [OFFSET_W-1:0]        md_rx_offset,
  input  logic [SIZE_W-1:0]          md_rx_size,
  output logic                       md_rx_ready,
  output logic                       md_rx_err,
  output logic                       out_valid,
  output logic [ALGN_DATA_WIDTH-1:0] out_data,
  output logic [OFFSET_W-1:0]        out_offset,
  output logic [SIZE_W-1:0]          out_size,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           fifo_lvl,
  output logic [7:0]                 err_cnt
);

  localparam int ENTRY_W = ALGN_DATA_WIDTH + OFFSET_W + SIZE_W;

  md_state_t          state;
  logic               legal;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;

  assign legal = md_legal(32'(md_rx_offset), 32'(md_rx_size), 32'(BUS_BYTES));

  // The master holds its fields until ready, so the RESP cycle pushes the
  // same fields that were judged legal in IDLE.
  assign fifo_push = (state == RESP) && !md_rx_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      md_rx_ready <= 1'b0;
      md_rx_err   <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          // Illegal transfers need no slot, so they are answered at full too.
          if (md_rx_valid && (!fifo_full || !legal)) begin
            state       <= RESP;
            md_rx_ready <= 1'b1;
            md_rx_err   <= !legal;
          end
        end
        RESP: begin
          state       <= IDLE;
          md_rx_ready <= 1'b0;
          md_rx_err   <= 1'b0;
          if (md_rx_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
          end
        end
        default: begin
          state       <= IDLE;
          md_rx_ready <= 1'b0;
          md_rx_err   <= 1'b0;
        end
      endcase
    end
  end

  md_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({md_rx_data, md_rx_offset, md_rx_size}),
    .pop       (out_ready),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .lvl       (fifo_lvl)
  );

  assign out_valid = !fifo_empty;
  assign {out_data, out_offset, out_size} = fifo_head;

endmodule

// File: tb/tb_md_rx_ctrl.sv
// tb/tb_md_rx_ctrl.sv - self-checking bench for md_rx_ctrl
module tb_md_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_rx_valid;
  logic [31:0] md_rx_data;
  logic [1:0]  md_rx_offset;
  logic [2:0]  md_rx_size;
  logic        md_rx_ready;
  logic        md_rx_err;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_offset;
  logic [2:0]  out_size;
  logic        out_ready;
  logic [2:0]  fifo_lvl;
  logic [7:0]  err_cnt;

  logic dir_rdy = 1'b0;
  logic rnd_rdy = 1'b0;
  bit   rnd_en = 1'b0;
  assign out_ready = rnd_en ? rnd_rdy : dir_rdy;

  always #5 clk = ~clk;

  md_rx_ctrl #(
    .ALGN_DATA_WIDTH (32),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .md_rx_valid  (md_rx_valid),
    .md_rx_data   (md_rx_data),
    .md_rx_offset (md_rx_offset),
    .md_rx_size   (md_rx_size),
    .md_rx_ready  (md_rx_ready),
    .md_rx_err    (md_rx_err),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_offset   (out_offset),
    .out_size     (out_size),
    .out_ready    (out_ready),
    .fifo_lvl     (fifo_lvl),
    .err_cnt      (err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of the port.
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  off;
    logic [2:0]  size;
  } ent_t;

  ent_t mq[$];
  bit   m_ready = 1'b0;
  bit   m_err = 1'b0;
  int   m_errcnt = 0;
  bit   chk_en = 1'b0;

  function automatic bit legal_f(input int off, input int size);
    if (size == 0) return 1'b0;
    return (off + size <= 4) && (off % size == 0);
  endfunction

  always @(posedge clk) begin : model
    bit nr;
    bit ne;
    int lvl0;
    if (reset) begin
      m_ready  = 1'b0;
      m_err    = 1'b0;
      m_errcnt = 0;
      mq.delete();
    end else begin
      lvl0 = mq.size();
      nr = 1'b0;
      ne = 1'b0;
      if (m_ready) begin
        if (m_err && m_errcnt < 255) m_errcnt++;
      end else if (md_rx_valid &&
                   (lvl0 < 4 || !legal_f(int'(md_rx_offset), int'(md_rx_size)))) begin
        nr = 1'b1;
        ne = !legal_f(int'(md_rx_offset), int'(md_rx_size));
      end
      if (out_ready && lvl0 > 0) void'(mq.pop_front());
      if (m_ready && !m_err) mq.push_back('{md_rx_data, md_rx_offset, md_rx_size});
      m_ready = nr;
      m_err   = ne;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", 64'(md_rx_ready), 64'(m_ready));
      chk("m_err", 64'(md_rx_err), 64'(m_err));
      chk("m_err_needs_ready", 64'(md_rx_err && !md_rx_ready), 64'd0);
      chk("m_lvl", 64'(fifo_lvl), 64'(mq.size()));
      chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("m_err_cnt", 64'(err_cnt), 64'(m_errcnt));
      if (mq.size() > 0) chk("m_head", 64'({out_data, out_offset, out_size}), 64'(mq[0]));
    end
  end

  always @(negedge clk) begin
    if (rnd_en) rnd_rdy = 1'($urandom_range(0, 1));
  end

  bit t5_on = 1'b0;
  int t5_max = 0;
  always @(negedge clk) begin
    if (t5_on && int'(fifo_lvl) > t5_max) t5_max = int'(fifo_lvl);
  end

  task automatic send(input logic [1:0] off, input logic [2:0] size, input logic [31:0] data,
                      output int lat, output bit err);
    bit got;
    got = 1'b0;
    lat = 0;
    err = 1'b0;
    md_rx_valid  = 1'b1;
    md_rx_offset = off;
    md_rx_size   = size;
    md_rx_data   = data;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (md_rx_ready) begin
        got = 1'b1;
        lat = i;
        err = md_rx_err;
      end
    end
    chk("send_done", 64'(got), 64'd1);
    @(negedge clk);
    md_rx_valid = 1'b0;
  endtask

  task automatic drain();
    dir_rdy = 1'b1;
    for (int i = 0; i < 20 && out_valid; i++) @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'd0);
    dir_rdy = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  e;
    time t0;
    logic [2:0] ill_sz [3];
    logic [1:0] ill_of [3];
    ill_of[0] = 2'd1; ill_sz[0] = 3'd2;
    ill_of[1] = 2'd2; ill_sz[1] = 3'd4;
    ill_of[2] = 2'd0; ill_sz[2] = 3'd0;

    reset = 1'b1;
    md_rx_valid = 1'b0;
    md_rx_data = '0;
    md_rx_offset = '0;
    md_rx_size = '0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ready", 64'(md_rx_ready), 64'd0);
    chk("rst_err", 64'(md_rx_err), 64'd0);
    chk("rst_lvl", 64'(fifo_lvl), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: single legal transfer
    md_rx_valid = 1'b1; md_rx_offset = 2'd0; md_rx_size = 3'd4; md_rx_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_ready", 64'(md_rx_ready), 64'd1);
    chk("t1_err", 64'(md_rx_err), 64'd0);
    chk("t1_no_out_yet", 64'(out_valid), 64'd0);
    @(negedge clk);
    md_rx_valid = 1'b0;
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_data", 64'(out_data), 64'hDEADBEEF);
    chk("t1_out_offset", 64'(out_offset), 64'd0);
    chk("t1_out_size", 64'(out_size), 64'd4);
    chk("t1_lvl", 64'(fifo_lvl), 64'd1);
    drain();

    // 2: illegal transfers
    for (int i = 0; i < 3; i++) begin
      send(ill_of[i], ill_sz[i], 32'hBAD0 + 32'(i), lat, e);
      chk("t2_err", 64'(e), 64'd1);
    end
    chk("t2_err_cnt", 64'(err_cnt), 64'd3);
    chk("t2_lvl", 64'(fifo_lvl), 64'd0);

    // 3: fill, then a held fifth transfer released by a one-cycle pop
    for (int i = 0; i < 4; i++) send(2'd0, 3'd4, 32'h100 + 32'(i), lat, e);
    chk("t3_full", 64'(fifo_lvl), 64'd4);
    md_rx_valid = 1'b1; md_rx_offset = 2'd2; md_rx_size = 3'd2; md_rx_data = 32'h104;
    repeat (3) begin
      @(negedge clk);
      chk("t3_held", 64'(md_rx_ready), 64'd0);
    end
    dir_rdy = 1'b1;
    @(negedge clk);
    dir_rdy = 1'b0;
    chk("t3_not_yet", 64'(md_rx_ready), 64'd0);
    chk("t3_head_after_pop", 64'(out_data), 64'h101);
    @(negedge clk);
    chk("t3_ready", 64'(md_rx_ready), 64'd1);
    chk("t3_err", 64'(md_rx_err), 64'd0);
    @(negedge clk);
    md_rx_valid = 1'b0;
    chk("t3_full_again", 64'(fifo_lvl), 64'd4);

    // 4: illegal at full
    send(2'd3, 3'd2, 32'h5555, lat, e);
    chk("t4_latency", 64'(lat), 64'd1);
    chk("t4_err", 64'(e), 64'd1);
    chk("t4_lvl", 64'(fifo_lvl), 64'd4);
    chk("t4_err_cnt", 64'(err_cnt), 64'd4);
    drain();

    // 5: streaming with the sink always ready
    dir_rdy = 1'b1;
    t5_on = 1'b1;
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      send(2'(i % 4), 3'd1, 32'hA000 + 32'(i), lat, e);
      chk("t5_latency", 64'(lat), 64'd1);
    end
    chk("t5_cycles", 64'(($time - t0) / 10), 64'd16);
    @(negedge clk);
    t5_on = 1'b0;
    chk("t5_max_lvl", 64'(t5_max), 64'd1);
    dir_rdy = 1'b0;

    // 6: reset during the ready cycle
    md_rx_valid = 1'b1; md_rx_offset = 2'd0; md_rx_size = 3'd2; md_rx_data = 32'h6666;
    @(negedge clk);
    chk("t6_ready", 64'(md_rx_ready), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    md_rx_valid = 1'b0;
    reset = 1'b0;
    chk("t6_ready0", 64'(md_rx_ready), 64'd0);
    chk("t6_err0", 64'(md_rx_err), 64'd0);
    chk("t6_lvl0", 64'(fifo_lvl), 64'd0);
    chk("t6_out_valid0", 64'(out_valid), 64'd0);
    chk("t6_err_cnt0", 64'(err_cnt), 64'd0);
    @(negedge clk);
    chk("t6_no_push", 64'(out_valid), 64'd0);

    // randomized traffic with a randomly stalling sink
    rnd_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, lat, e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rnd_en = 1'b0;
    drain();

    // error counter saturation
    for (int i = 0; i < 260; i++) send(2'd1, 3'd4, 32'(i), lat, e);
    chk("sat_err_cnt", 64'(err_cnt), 64'd255);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
